// File: rtl/edge_event_arbiter_if.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter_if
// Event handshake channel between edge_event_arbiter and one consumer.
//   o_valid  : event available (driven by master)
//   o_id     : channel index of the presented event (driven by master)
//   in_ready : consumer accepts the event when high with o_valid (driven by slave)
// ---------------------------------------------------------------------------
interface edge_event_arbiter_if #(
   parameter int N = 4
) ();
   localparam int IDW = $clog2(N);

   logic           o_valid;
   logic [IDW-1:0] o_id;
   logic           in_ready;

   modport master (output o_valid, output o_id, input in_ready);
   modport slave  (input o_valid, input o_id, output in_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter
// Per-channel rising-edge detection with a pending-event latch, serialised
// onto a single valid/ready channel by a round-robin arbiter.
//   in_clk     : system clock, all state updates on the rising edge
//   in_rst     : synchronous active-high reset
//   in_i       : N level inputs
//   o_overflow : sticky per-channel "edge lost" flag, cleared only by in_rst
//   ev         : event channel (o_valid, o_id out; in_ready in)
// ---------------------------------------------------------------------------
module edge_event_arbiter #(
   parameter int N = 4
) (
   input  logic                  in_clk,
   input  logic                  in_rst,
   input  logic [N-1:0]          in_i,
   output logic [N-1:0]          o_overflow,
   edge_event_arbiter_if.master  ev
);
   localparam int IDW = $clog2(N);

   logic [N-1:0]   prev_p0;
   logic [N-1:0]   pend_p1;
   logic [IDW-1:0] ptr_p1;

   logic [N-1:0]   rise;
   logic [N-1:0]   load_mask;
   logic [IDW-1:0] grant_id;
   logic           grant_found;
   logic           out_free;
   int             scan_idx;

   // Explicit wrap so non-power-of-two N never produces an index >= N.
   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
      if (int'(idx) == N - 1) return '0;
      return IDW'(int'(idx) + 1);
   endfunction

   // Stage 0: edge detection against the previous sample
   assign rise     = in_i & ~prev_p0;
   assign out_free = !ev.o_valid || ev.in_ready;

   // Stage 1: round-robin search over registered pending bits only, so a
   // rise in this cycle cannot win until the next one.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      scan_idx    = 0;
      for (int k = 0; k < N; k++) begin
         scan_idx = int'(ptr_p1) + k;
         if (scan_idx >= N) scan_idx = scan_idx - N;
         if (!grant_found && pend_p1[IDW'(scan_idx)]) begin
            grant_found = 1'b1;
            grant_id    = IDW'(scan_idx);
         end
      end
   end

   always_comb begin
      load_mask = '0;
      if (out_free && grant_found) load_mask[grant_id] = 1'b1;
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         prev_p0    <= '0;
         pend_p1    <= '0;
         ptr_p1     <= '0;
         o_overflow <= '0;
         ev.o_valid <= 1'b0;
         ev.o_id    <= '0;
      end else begin
         prev_p0    <= in_i;
         // A rise in the same cycle as the load re-arms the latch (set wins).
         pend_p1    <= (pend_p1 & ~load_mask) | rise;
         // An edge is lost only if the latch is already full and not being drained.
         o_overflow <= o_overflow | (rise & pend_p1 & ~load_mask);
         // Stage 2: output register; frozen while stalled by the consumer
         if (out_free) begin
            ev.o_valid <= grant_found;
            if (grant_found) begin
               ev.o_id <= grant_id;
               ptr_p1  <= wrap_inc(grant_id);
            end
         end
      end
   end
endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event controller for the rising-edge detector datapath. Each of N input lines gets its own rising-edge detector and a pending-event latch. A round-robin arbiter serialises the pending events onto one valid/ready channel that reports the channel index. The block sits between raw level inputs and a single consumer, for example an interrupt or event-logging unit, that handles one event per handshake.

## Interface
- N, default 4: number of input channels (2..16).
- IDW, localparam = $clog2(N): width of the channel index.
- in_clk  input  1  system clock; all state updates on its rising edge.
- in_rst  input  1  reset; synchronous, active-high.
- in_i  input  N  level inputs, one per channel; sampled on in_clk rising edge.
- in_ready  input  1  consumer accepts the current event when high together with o_valid.
- o_valid  output  1  event available on o_id.
- o_id  output  IDW  index of the channel whose event is presented.
- o_overflow  output  N  sticky per-channel flag: an edge was lost. Cleared only by in_rst.

## Operation
- Per channel, a prev register holds in_i from the previous edge. rise[c] = in_i[c] & ~prev[c].
  - A level held high produces exactly one rise.
  - Falling edges are ignored.
- pending[c]:
  - Set on rise[c].
  - Cleared when channel c is loaded into the output register.
  - If rise[c] and the clear happen in the same cycle, set wins and pending[c] stays 1.
- Overflow: rise[c] while pending[c]=1 and c is not loaded this cycle sets o_overflow[c]=1. The extra edge is dropped; pending stays 1.
- Arbiter:
  - Runs when the output register is free, i.e. o_valid=0, or o_valid=1 & in_ready=1.
  - Uses registered pending values only. This cycle's rise is not eligible.
  - Searches from pointer ptr upward, modulo N. The first pending channel c wins.
  - On a win: o_valid<=1, o_id<=c, pending[c] cleared, ptr<=(c+1) mod N.
  - If the register is free and nothing is pending: o_valid<=0, o_id holds its last value, ptr unchanged.
- Hold rule: while o_valid=1 & in_ready=0, o_id and o_valid are frozen and the arbiter does not run.
- Handshake: one event is transferred on each cycle with o_valid=1 & in_ready=1. Back-to-back transfers at one per cycle are supported.

## Timing
- Reset: when in_rst=1 at an edge, on that edge:
  - prev, pending, ptr, o_id and o_overflow go to 0, and o_valid goes to 0.
  - Any event in flight is discarded, with no handshake required.
  - This applies mid-operation with the same result.
- Reset release: prev resets to 0, so a channel whose in_i is already high at the first edge after release produces a rise and one event.
- Latency, with the register free and no competition:
  - In_i first sampled high at edge k sets pending after edge k.
  - o_valid=1 with o_id=c after edge k+1.
  - Total: 2 edges from sampled input to presented event.
- Throughput: N simultaneous rises, with in_ready held high, drain in N consecutive cycles in round-robin order starting at ptr.
- Fairness: a pending channel waits at most N-1 grants before being served.
- Width rules:
  - ptr and o_id are IDW bits.
  - For non-power-of-two N, wrap is explicit: index N-1 wraps to 0.
  - Indices >= N are never produced.

## Test plan
- Reset: in_rst=1 for 1 cycle with in_i=4'b0000 → o_valid=0, o_id=0, o_overflow=4'b0000.
- Single edge:
  - Stimulus: in_i[2] goes 0→1 at edge k and stays high; in_ready=1.
  - Response: o_valid=1, o_id=2 for exactly the cycle after edge k+1, then o_valid=0. No further events while the line stays high.
- Simultaneous edges:
  - Stimulus: in_i 4'b0000→4'b1011 at edge k; ptr=0; in_ready=1.
  - Response: o_id=0, 1, 3 on three consecutive cycles; o_valid drops afterwards; ptr=0 at the end.
- Round-robin order:
  - Stimulus: after a grant to channel 1 (ptr=2), channels 0 and 2 become pending.
  - Response: grant 2 first, then 0.
- Backpressure and overflow:
  - Stimulus: event on ch1 with in_ready=0 for 6 cycles.
  - o_id=1 and o_valid=1 remain stable throughout.
  - A second rise on ch1 during the stall sets pending[1], with no overflow.
  - A third rise on ch1 sets o_overflow=4'b0010.
  - After in_ready=1, ch1 is presented twice in total and o_overflow stays set.
- Reset mid-operation:
  - Stimulus: o_valid=1 and pending=4'b0110; in_rst=1 for 1 cycle while in_i=4'b0100 is held.
  - At reset: all state clears.
  - After release: exactly one event with o_id=2 and o_overflow=0.
